dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port (wen/addr/wdata/rdata) between two requesters.
//  Port 0 is the CPU data port; port 1 is the loader/checker port used by the bench and debug.
//  Ownership is burst-locked and passes round-robin; one access per cycle is accepted.
//  Read data is registered and returned one cycle after acceptance.
// PARAMETERS
//  AW         32  address width, bytes
//  DW         32  data width
//  BURST_MAX  4   max consecutive accepted beats for the owner while the other port waits (>=1)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req0_valid   in   1   port 0 request
//  req0_wen     in   1   1=write, 0=read
//  req0_addr    in   AW  byte address
//  req0_wdata   in   DW  write data
//  req0_ready   out  1   request accepted this cycle (combinational)
//  rsp0_valid   out  1   read data valid (registered)
//  rsp0_rdata   out  DW  read data
//  req1_*/rsp1_*         same set for port 1
//  mem_wen      out  1   memory write enable
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  memory read data, combinational from mem_addr
//  owner        out  2   current owner: 00 none, 01 port 0, 10 port 1 (registered)
//  stat_gnt0    out  16  accepted beats, port 0 (see CONFIGURATION)
//  stat_gnt1    out  16  accepted beats, port 1
//  stat_conf    out  16  cycles with both ports valid
// BEHAVIOUR
//  - Reset: FSM=IDLE, burst_cnt=0, last=1 (port 0 wins the first tie), owner=00, rsp*_valid=0,
//    rsp*_rdata=0, stat_*=0. mem_wen=0 while reset is asserted and whenever no grant is made.
//  - FSM states IDLE, OWN0, OWN1. The owner is the only port that can be granted.
//  - IDLE: if one port is valid, grant it and move to OWNx.
//    If both are valid, grant the port != last.
//  - OWNx while reqx_valid=1: grant x. burst_cnt+=1 on each accepted beat while the other port is valid.
//  - Handover: when burst_cnt reaches BURST_MAX with the other port valid, ownership passes to
//    the other port the next cycle (OWN0<->OWN1), burst_cnt clears and last updates.
//  - OWNx with reqx_valid=0: the other port is granted in the same cycle if valid (state becomes OWNy).
//    Otherwise the FSM returns to IDLE. No cycle is lost when a single port is idle.
//  - burst_cnt clears on every ownership change and whenever the other port is not valid.
//  - Grant cycle: reqx_ready=1. mem_addr, mem_wdata and mem_wen are driven from port x combinationally.
//    At most one ready per cycle. No grant drives mem_addr=0 and mem_wen=0.
//  - Requester rule: hold valid, wen, addr and wdata stable until ready.
//    The arbiter never drops an unaccepted request.
//  - Read accepted at cycle N: rspx_rdata=mem_rdata sampled at edge N, rspx_valid=1 in cycle N+1 only.
//    Writes produce no response. Reads back-to-back give one rsp per cycle, in order.
//  - rspx_rdata holds its last value when rspx_valid=0.
//  - Read-after-write to the same address on consecutive cycles returns the new data,
//    because the memory writes at edge N.
//  - Async reset mid-burst: pending responses are discarded and the FSM returns to IDLE.
//    Requesters re-issue their requests.
// CONFIGURATION
//  - DMEM_ARB_STATS_EN defined: stat_gnt0 and stat_gnt1 count accepted beats per port.
//    stat_conf counts cycles with req0_valid&req1_valid. All three are 16-bit saturating (hold at 16'hFFFF).
//  - Not defined: stat_* are tied to 0 and no counter flops are built. Port list is unchanged.
// TESTING
//  - Single port: port0 reads 0x10,0x14,0x18 back-to-back ->
//    ready each cycle, rsp0_valid in cycles 2-4 with mem contents in order.
//  - Tie at IDLE after reset: both valid, read 0x0 and 0x4 -> port0 granted first.
//    Port1 granted the cycle port0 drops valid.
//  - Burst lock, BURST_MAX=4: both valid continuously ->
//    grants 0,0,0,0,1,1,1,1,0,... with owner tracking each change one cycle later.
//  - Write then read: port1 writes 0xDEADBEEF to 0x20, then reads 0x20 next cycle ->
//    rsp1_rdata=0xDEADBEEF. mem_wen high for exactly one cycle.
//  - Reset mid-burst: rst_n low for 2 cycles during an outstanding read ->
//    rsp*_valid=0, owner=00, mem_wen=0 immediately. First tie after release goes to port0.
//  - With DMEM_ARB_STATS_EN: 10 contended cycles, BURST_MAX=4 ->
//    stat_conf=10, stat_gnt0=6, stat_gnt1=4. Without the macro all stat_* read 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's handshake and registered read-response channel
interface dmem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic valid, wen, ready, rsp_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rsp_rdata;
  modport master(output valid, wen, addr, wdata, input ready, rsp_valid, rsp_rdata);
  modport slave(input valid, wen, addr, wdata, output ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: burst-locked round-robin sharing of one data-memory port; DMEM_ARB_STATS_EN builds grant/conflict counters
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic [15:0]   stat_gnt0,
  output logic [15:0]   stat_gnt1,
  output logic [15:0]   stat_conf
);
  localparam int CW = $clog2(BURST_MAX + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last, last_n, gv, g, vo, vt, vg, keep;
  // pick the granted port: owner keeps it until idle or its burst is spent while the other waits
  always_comb begin
    vo = state == OWN1 ? p1.valid : p0.valid;
    vt = state == OWN1 ? p0.valid : p1.valid;
    keep = vo & ~(vt & (cnt == CW'(BURST_MAX)));
    gv = rst_n & (p0.valid | p1.valid);
    g = state == IDLE ? ((p0.valid & p1.valid) ? ~last : p1.valid) : ((state == OWN1) ^ ~keep);
    vg = g ? p0.valid : p1.valid;
    state_n = gv ? (g ? OWN1 : OWN0) : IDLE;
    last_n = gv ? g : last;
    cnt_n = (gv & vg) ? ((state_n == state) ? cnt + 1'b1 : CW'(1)) : '0;
  end
  assign p0.ready = gv & ~g;
  assign p1.ready = gv & g;
  assign mem_wen = gv & (g ? p1.wen : p0.wen);
  assign mem_addr = gv ? (g ? p1.addr : p0.addr) : '0;
  assign mem_wdata = gv ? (g ? p1.wdata : p0.wdata) : '0;
  assign owner = state;
  // ownership state, round-robin pointer and burst length
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last <= last_n;
    end
  // read data captured at the accepting edge, valid for one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p0.rsp_valid <= 1'b0;
      p1.rsp_valid <= 1'b0;
      p0.rsp_rdata <= '0;
      p1.rsp_rdata <= '0;
    end else begin
      p0.rsp_valid <= p0.ready & ~p0.wen;
      p1.rsp_valid <= p1.ready & ~p1.wen;
      if (p0.ready & ~p0.wen) p0.rsp_rdata <= mem_rdata;
      if (p1.ready & ~p1.wen) p1.rsp_rdata <= mem_rdata;
    end
`ifdef DMEM_ARB_STATS_EN
  // saturating accepted-beat and contention counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_gnt0 <= '0;
      stat_gnt1 <= '0;
      stat_conf <= '0;
    end else begin
      if (p0.ready && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 1'b1;
      if (p1.ready && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 1'b1;
      if (p0.valid && p1.valid && stat_conf != 16'hFFFF) stat_conf <= stat_conf + 1'b1;
    end
`else
  assign stat_gnt0 = '0;
  assign stat_gnt1 = '0;
  assign stat_conf = '0;
`endif
endmodule
